enc_round_sequencer: RTL and testbench
======================================

# enc_round_sequencer

Multi-round controller for the 8-bit nibble-Feistel encryption datapath. Accepts one plaintext byte and one key byte per transaction over a valid/ready handshake. Runs the expansion / key-XOR / carry-select-add / nibble-XOR round function for a parameterised number of rounds, with a rotating key schedule. Returns the ciphertext over a second valid/ready handshake. Sits between the byte-stream front end and the result sink, replacing the single-shot encryption path.

## Interface
- ROUNDS, 4, number of rounds per block; legal range 1..15; width of the round counter is 4 bits
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low; clears all state immediately
- in_valid  input  1  in_data/in_key valid
- in_ready  output  1  block can accept a transaction (high only in IDLE)
- in_data  input  8  plaintext byte
- in_key  input  8  key byte
- out_valid  output  1  out_data valid
- out_ready  input  1  sink accepts out_data
- out_data  output  8  ciphertext byte
- busy  output  1  high in RUN or DONE
- mode  input  1  0 = encrypt, 1 = decrypt; present only with ENC_DECRYPT_EN

## Operation
- State register holds L (bits 7:4) and R (bits 3:0), round key K (8 bits), round counter cnt (4 bits) and FSM state.
- Round function F(R, K):
  - Expansion E[7:0] = {R3, R0, R1, R2, R1, R3, R2, R0}, listed MSB to LSB.
  - X = E ^ K.
  - S = (X[7:4] + X[3:0] + ~K[0]) mod 16. K[0] is the carry-select input: K[0]=1 adds 0, K[0]=0 adds 1. The carry-out is discarded.
- Each round updates {L, R} <= {R, L ^ F(R, K)}.
- After the final round, out_data = {R, L}, i.e. the last swap is undone.
- Key schedule, encrypt:
  - K is loaded with in_key.
  - K rotates left by 1 after each round, so round i uses rotl(in_key, i mod 8).
- FSM:
  - IDLE: in_ready=1. When in_valid is high, load {L,R}=in_data, load K, set cnt=0, go to RUN.
  - RUN: one round per clock. cnt increments. When cnt==ROUNDS-1, go to DONE (out_data captured in the same edge).
  - DONE: out_valid=1, out_data held stable. When out_ready is high, go to IDLE.
- Outside IDLE, in_valid/in_data/in_key are ignored. in_valid held high does not re-trigger a load.
- out_ready is ignored outside DONE.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_data=0x00, busy=0, L=R=K=cnt=0.
- Reset asserted mid-RUN or in DONE aborts the block. No output is produced, and the next transaction starts clean.

## Timing
- Accepting edge: the rising edge with in_valid & in_ready.
- out_valid rises exactly ROUNDS rising edges after the accepting edge.
- DONE→IDLE takes one edge after out_ready is sampled high.
- Minimum spacing between accepting edges is ROUNDS+2 edges when out_ready is held high.
- A back-pressured DONE holds out_valid/out_data indefinitely, with no data change.
- in_ready is registered; it falls on the accepting edge and rises on the DONE→IDLE edge.

## Configuration
- ENC_DECRYPT_EN defined: the mode port exists and is sampled on the accepting edge.
  - With mode=1, K loads rotl(in_key, (ROUNDS-1) mod 8) and rotates right by 1 each round.
  - The round and output-swap structure is unchanged, so decrypting a ciphertext with the same key and ROUNDS returns the plaintext.
- ENC_DECRYPT_EN undefined: no mode port; encrypt only; key register rotates left only.

## Test plan
- Reset check: reset low for 3 cycles → in_ready=1, out_valid=0, out_data=0x00, busy=0. Release reset, then send in_data=0x46, in_key=0x93 → accepted on the first valid edge.
- Single-round vector (ROUNDS=1): in_data=0x46, in_key=0x93 → out_valid one edge after acceptance, out_data=0x76.
- Latency and back-pressure (ROUNDS=4): any block, out_ready=0 for 10 cycles → out_valid rises exactly 4 edges after acceptance. out_data is constant while held, in_ready=0 throughout, and a second in_valid pulse during RUN/DONE is dropped.
- Round trip (ENC_DECRYPT_EN, ROUNDS=1 and ROUNDS=4): encrypt 256 random data/key pairs, decrypt each result with the same key → original byte returned every time. ROUNDS=1 decrypt of 0x76 with key 0x93 → 0x46.
- Mid-operation reset: assert reset two cycles into RUN (ROUNDS=4) → all outputs return to reset values immediately, and out_valid never pulses. The next transaction (0x46/0x93, ROUNDS=1) still yields 0x76.
- Back-to-back throughput: out_ready tied high, in_valid tied high with changing data → accepts spaced exactly ROUNDS+2 edges apart, with one out_valid pulse per accept, in order.

Source files
------------

// File: rtl/enc_round_sequencer.sv
// Multi-round nibble-Feistel encryption sequencer: valid/ready byte in, ROUNDS rounds, valid/ready byte out.
// Optional feature: define ENC_DECRYPT_EN to add the mode port (decrypt via reversed key schedule).
module enc_round_sequencer #(
  parameter int unsigned ROUNDS = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic [7:0] in_key,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       busy
`ifdef ENC_DECRYPT_EN
  ,
  input  logic       mode
`endif
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ROUNDS - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state, state_next;
  logic [3:0]       l, l_next;
  logic [3:0]       r, r_next;
  logic [7:0]       k, k_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [7:0]       out_data_next;
  logic [7:0]       key_load;
  logic [3:0]       f_val;
  logic [3:0]       r_new;

  // Round function: expansion, key mix, carry-select add (K[0]=0 injects +1).
  function automatic logic [3:0] round_f(input logic [3:0] rv, input logic [7:0] kv);
    logic [7:0] e;
    logic [7:0] x;
    e = {rv[3], rv[0], rv[1], rv[2], rv[1], rv[3], rv[2], rv[0]};
    x = e ^ kv;
    return x[7:4] + x[3:0] + {3'b000, ~kv[0]};
  endfunction

  assign f_val = round_f(r, k);
  assign r_new = l ^ f_val;

`ifdef ENC_DECRYPT_EN
  localparam int unsigned DEC_ROT = (ROUNDS - 1) % 8;

  logic dec, dec_next;

  // Decrypt starts from the last encrypt round key and walks backwards.
  assign key_load = mode ? 8'(({in_key, in_key} << DEC_ROT) >> 8) : in_key;
`else
  assign key_load = in_key;
`endif

  // Next-state and datapath update.
  always_comb begin
    state_next    = state;
    l_next        = l;
    r_next        = r;
    k_next        = k;
    cnt_next      = cnt;
    out_data_next = out_data;
`ifdef ENC_DECRYPT_EN
    dec_next      = dec;
`endif
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          l_next     = in_data[7:4];
          r_next     = in_data[3:0];
          k_next     = key_load;
          cnt_next   = '0;
`ifdef ENC_DECRYPT_EN
          dec_next   = mode;
`endif
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        l_next   = r;
        r_next   = r_new;
`ifdef ENC_DECRYPT_EN
        k_next   = dec ? {k[0], k[7:1]} : {k[6:0], k[7]};
`else
        k_next   = {k[6:0], k[7]};
`endif
        cnt_next = cnt + CNT_W'(1);
        if (cnt == LAST_CNT) begin
          // Output undoes the final swap: {R, L} of the post-round state.
          out_data_next = {r_new, r};
          state_next    = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State register with registered handshake/status outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      l         <= '0;
      r         <= '0;
      k         <= '0;
      cnt       <= '0;
      out_data  <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef ENC_DECRYPT_EN
      dec       <= 1'b0;
`endif
    end else begin
      state     <= state_next;
      l         <= l_next;
      r         <= r_next;
      k         <= k_next;
      cnt       <= cnt_next;
      out_data  <= out_data_next;
      in_ready  <= (state_next == ST_IDLE);
      out_valid <= (state_next == ST_DONE);
      busy      <= (state_next != ST_IDLE);
`ifdef ENC_DECRYPT_EN
      dec       <= dec_next;
`endif
    end
  end

endmodule

// File: tb/tb_enc_round_sequencer.sv
// Bench for enc_round_sequencer: ROUNDS=1 and ROUNDS=4 instances against an index-based reference model.
module tb_enc_round_sequencer;

  localparam int R_A = 1;
  localparam int R_B = 4;

  logic            clock;
  logic            reset;
  logic [1:0]      in_valid;
  logic [1:0]      in_ready;
  logic [1:0][7:0] in_data;
  logic [1:0][7:0] in_key;
  logic [1:0]      out_valid;
  logic [1:0]      out_ready;
  logic [1:0][7:0] out_data;
  logic [1:0]      busy;
`ifdef ENC_DECRYPT_EN
  logic [1:0]      mode;
`endif

  int errors = 0;
  int checks = 0;

  enc_round_sequencer #(.ROUNDS(R_A)) dut_a (
    .clock(clock), .reset(reset),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]), .in_key(in_key[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]), .busy(busy[0])
`ifdef ENC_DECRYPT_EN
    , .mode(mode[0])
`endif
  );

  enc_round_sequencer #(.ROUNDS(R_B)) dut_b (
    .clock(clock), .reset(reset),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]), .in_key(in_key[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]), .busy(busy[1])
`ifdef ENC_DECRYPT_EN
    , .mode(mode[1])
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic int rounds_of(input int u);
    return (u == 0) ? R_A : R_B;
  endfunction

  function automatic int rotl_ref(input int v, input int n);
    int m;
    m = n % 8;
    return ((v << m) | (v >> (8 - m))) & 255;
  endfunction

  function automatic int f_ref(input int rv, input int kv);
    int e, x;
    e = (((rv >> 3) & 1) << 7) | ((rv & 1) << 6) | (((rv >> 1) & 1) << 5) | (((rv >> 2) & 1) << 4)
      | (((rv >> 1) & 1) << 3) | (((rv >> 3) & 1) << 2) | (((rv >> 2) & 1) << 1) | (rv & 1);
    x = e ^ kv;
    return ((x >> 4) + (x & 15) + (((kv & 1) != 0) ? 0 : 1)) % 16;
  endfunction

  // Round i uses rotl(key, i) for encrypt and rotl(key, rounds-1-i) for decrypt.
  function automatic logic [7:0] model(input int d, input int kv, input int rounds, input logic dec);
    int lv, rv, ki, t;
    lv = (d >> 4) & 15;
    rv = d & 15;
    for (int i = 0; i < rounds; i++) begin
      ki = dec ? rotl_ref(kv, rounds - 1 - i) : rotl_ref(kv, i);
      t  = lv ^ f_ref(rv, ki);
      lv = rv;
      rv = t;
    end
    return 8'((rv << 4) | lv);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic run_block(input int u, input logic [7:0] d, input logic [7:0] kv, input logic md,
                           input int hold, input bit drop, output logic [7:0] res);
    int lat;
    logic [7:0] held;
    check("accept_ready", 32'(in_ready[u]), 32'd1);
    in_valid[u] = 1'b1;
    in_data[u]  = d;
    in_key[u]   = kv;
`ifdef ENC_DECRYPT_EN
    mode[u]     = md;
`endif
    tick();
    in_valid[u] = 1'b0;
    check("in_ready_fall", 32'(in_ready[u]), 32'd0);
    check("busy_run", 32'(busy[u]), 32'd1);
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      if (drop && c == 2) begin
        in_valid[u]  = 1'b1;
        in_data[u]   = d ^ 8'hFF;
        out_ready[u] = 1'b1;
      end else begin
        in_valid[u]  = 1'b0;
        out_ready[u] = 1'b0;
      end
      tick();
      if (out_valid[u]) begin
        lat = c;
        break;
      end
    end
    in_valid[u]  = 1'b0;
    out_ready[u] = 1'b0;
    check("latency", 32'(lat), 32'(rounds_of(u)));
    res  = out_data[u];
    held = res;
    check("result", 32'(res), 32'(model(32'(d), 32'(kv), rounds_of(u), md)));
    for (int h = 0; h < hold; h++) begin
      in_valid[u] = (drop && h == 3);
      tick();
      check("hold_valid", 32'(out_valid[u]), 32'd1);
      check("hold_data", 32'(out_data[u]), 32'(held));
      check("hold_in_ready", 32'(in_ready[u]), 32'd0);
    end
    in_valid[u]  = 1'b0;
    out_ready[u] = 1'b1;
    tick();
    out_ready[u] = 1'b0;
    check("release_valid", 32'(out_valid[u]), 32'd0);
    check("release_in_ready", 32'(in_ready[u]), 32'd1);
    check("release_busy", 32'(busy[u]), 32'd0);
    if (drop) begin
      tick();
      check("no_retrigger_ready", 32'(in_ready[u]), 32'd1);
      check("no_retrigger_busy", 32'(busy[u]), 32'd0);
    end
  endtask

  task automatic back_to_back(input int u, input int n_acc);
    logic [7:0] exp_q[$];
    logic [7:0] e;
    int edge_n, last_acc, accepts, r;
    bit acc;
    r        = rounds_of(u);
    edge_n   = 0;
    last_acc = -1;
    accepts  = 0;
    out_ready[u] = 1'b1;
    in_valid[u]  = 1'b1;
`ifdef ENC_DECRYPT_EN
    mode[u]      = 1'b0;
`endif
    in_data[u]   = 8'($urandom);
    in_key[u]    = 8'($urandom);
    for (int c = 0; c < n_acc * (r + 2) + 10; c++) begin
      acc = in_valid[u] && in_ready[u];
      if (acc) exp_q.push_back(model(32'(in_data[u]), 32'(in_key[u]), r, 1'b0));
      tick();
      edge_n++;
      if (acc) begin
        accepts++;
        if (last_acc >= 0) check("b2b_spacing", 32'(edge_n - last_acc), 32'(r + 2));
        last_acc = edge_n;
        if (accepts == n_acc) in_valid[u] = 1'b0;
      end
      if (out_valid[u]) begin
        if (exp_q.size() == 0) begin
          check("b2b_extra_pulse", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("b2b_data", 32'(out_data[u]), 32'(e));
        end
      end
      in_data[u] = 8'($urandom);
      in_key[u]  = 8'($urandom);
    end
    in_valid[u]  = 1'b0;
    out_ready[u] = 1'b0;
    check("b2b_accepts", 32'(accepts), 32'(n_acc));
    check("b2b_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [7:0] res;
    logic [7:0] d, kv;
`ifdef ENC_DECRYPT_EN
    logic [7:0] back;
`endif
    reset     = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    in_key    = '0;
    out_ready = '0;
`ifdef ENC_DECRYPT_EN
    mode      = '0;
`endif

    // Reset state on both instances.
    repeat (3) tick();
    for (int u = 0; u < 2; u++) begin
      check("rst_in_ready", 32'(in_ready[u]), 32'd1);
      check("rst_out_valid", 32'(out_valid[u]), 32'd0);
      check("rst_out_data", 32'(out_data[u]), 32'd0);
      check("rst_busy", 32'(busy[u]), 32'd0);
    end
    reset = 1'b1;
    tick();

    // Known vector, single round.
    run_block(0, 8'h46, 8'h93, 1'b0, 0, 1'b0, res);
    check("vector_0x46_0x93", 32'(res), 32'h76);

    // Latency, back-pressure and dropped pulses with four rounds.
    run_block(1, 8'h46, 8'h93, 1'b0, 10, 1'b1, res);
    run_block(1, 8'hC3, 8'h5E, 1'b0, 10, 1'b1, res);

`ifdef ENC_DECRYPT_EN
    run_block(0, 8'h76, 8'h93, 1'b1, 0, 1'b0, res);
    check("decrypt_0x76_0x93", 32'(res), 32'h46);
`endif

    // Random blocks, boundary bytes included.
    for (int i = 0; i < 256; i++) begin
      for (int u = 0; u < 2; u++) begin
        d  = (i < 4) ? 8'((i[0]) ? 8'hFF : 8'h00) : 8'($urandom);
        kv = (i < 4) ? 8'((i[1]) ? 8'hFF : 8'h00) : 8'($urandom);
        run_block(u, d, kv, 1'b0, 0, 1'b0, res);
`ifdef ENC_DECRYPT_EN
        run_block(u, res, kv, 1'b1, 0, 1'b0, back);
        check("round_trip", 32'(back), 32'(d));
`endif
      end
    end

    // Reset two cycles into RUN aborts the block.
    in_valid[1] = 1'b1;
    in_data[1]  = 8'h5A;
    in_key[1]   = 8'h3C;
    tick();
    in_valid[1] = 1'b0;
    tick();
    tick();
    check("pre_abort_busy", 32'(busy[1]), 32'd1);
    reset = 1'b0;
    #1;
    check("abort_in_ready", 32'(in_ready[1]), 32'd1);
    check("abort_out_valid", 32'(out_valid[1]), 32'd0);
    check("abort_out_data", 32'(out_data[1]), 32'd0);
    check("abort_busy", 32'(busy[1]), 32'd0);
    for (int c = 0; c < 4; c++) begin
      tick();
      check("abort_no_valid", 32'(out_valid[1]), 32'd0);
    end
    reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      check("post_abort_no_valid", 32'(out_valid[1]), 32'd0);
      check("post_abort_in_ready", 32'(in_ready[1]), 32'd1);
    end
    run_block(0, 8'h46, 8'h93, 1'b0, 0, 1'b0, res);
    check("post_abort_vector", 32'(res), 32'h76);
    run_block(1, 8'h46, 8'h93, 1'b0, 2, 1'b0, res);

    // Streaming throughput.
    back_to_back(0, 6);
    back_to_back(1, 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
